// File: rtl/controle_servo_multicanal.sv
// Multi-channel hobby-servo PWM controller.
// One shared period counter drives NUM_CANAIS pulse outputs. Each channel keeps
// a target width (written by the host) and a current width that walks toward
// the target by at most PASSO clocks, only at period boundaries, so a pulse
// never changes length while it is being generated.
module controle_servo_multicanal #(
    parameter int  NUM_CANAIS  = 4,
    parameter int  POS_BITS    = 8,
    parameter int  PERIODO     = 1_000_000,
    parameter int  LARGURA_MIN = 50_000,
    parameter int  INCREMENTO  = 196,
    parameter int  PASSO       = 500,
    localparam int CANAL_W     = (NUM_CANAIS > 1) ? $clog2(NUM_CANAIS) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  escreve,
    input  logic [CANAL_W-1:0]    canal,
    input  logic [POS_BITS-1:0]   posicao,
    input  logic                  habilita,
    output logic [NUM_CANAIS-1:0] controle,
    output logic [NUM_CANAIS-1:0] em_movimento,
    output logic                  db_controle,
    output logic                  db_fim_periodo
);

    localparam int CONT_W      = $clog2(PERIODO);
    // One extra bit so width arithmetic never wraps.
    localparam int LARG_W      = CONT_W + 1;
    localparam int LARGURA_MAX = LARGURA_MIN + (2**POS_BITS - 1) * INCREMENTO;
    // A step larger than the whole position range is the same as jumping.
    localparam int PASSO_EF    = (PASSO > LARGURA_MAX) ? 0 : PASSO;

    localparam logic [LARG_W-1:0] MIN_W   = LARG_W'(LARGURA_MIN);
    localparam logic [LARG_W-1:0] PASSO_W = LARG_W'(PASSO_EF);
    localparam logic [CONT_W-1:0] ULTIMO  = CONT_W'(PERIODO - 1);

    // The widest pulse must fit inside one period.
    if (LARGURA_MAX >= PERIODO) begin : g_param_check
        $error("controle_servo_multicanal: LARGURA_MAX must be below PERIODO");
    end

    logic [CONT_W-1:0]     r_contador;
    logic [LARG_W-1:0]     r_atual [NUM_CANAIS];
    logic [LARG_W-1:0]     r_alvo  [NUM_CANAIS];
    logic [NUM_CANAIS-1:0] r_hab;
    logic [NUM_CANAIS-1:0] r_controle;
    logic                  r_fim_periodo;

    logic                  w_fim;
    logic                  w_canal_valido;
    logic                  w_escrita_valida;
    logic [LARG_W-1:0]     w_alvo_novo;
    logic [LARG_W-1:0]     w_atual_prox [NUM_CANAIS];
    logic [NUM_CANAIS-1:0] w_movimento;

    assign w_fim            = (r_contador == ULTIMO);
    assign w_canal_valido   = (32'(canal) < 32'(NUM_CANAIS));
    assign w_escrita_valida = escreve && w_canal_valido;
    assign w_alvo_novo      = MIN_W + LARG_W'(posicao) * LARG_W'(INCREMENTO);

    // Shared period counter, 0..PERIODO-1 then wrap.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_contador <= '0;
        end else if (w_fim) begin
            r_contador <= '0;
        end else begin
            r_contador <= r_contador + CONT_W'(1);
        end
    end

    // Next current width per channel: one step toward the target, clamped at it.
    always_comb begin
        for (int i = 0; i < NUM_CANAIS; i++) begin
            // NOTE: default first so every path assigns it; a missing default here would infer a latch.
            w_atual_prox[i] = r_alvo[i];
            if (PASSO_EF != 0) begin
                if ((r_alvo[i] > r_atual[i]) && ((r_alvo[i] - r_atual[i]) > PASSO_W)) begin
                    w_atual_prox[i] = r_atual[i] + PASSO_W;
                end else if ((r_atual[i] > r_alvo[i]) && ((r_atual[i] - r_alvo[i]) > PASSO_W)) begin
                    w_atual_prox[i] = r_atual[i] - PASSO_W;
                end
            end
        end
    end

    // Channel state: ramp at the period boundary, host writes any cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: these per-channel arrays are control state, not a RAM, so every entry is reset.
            for (int i = 0; i < NUM_CANAIS; i++) begin
                r_atual[i] <= MIN_W;
                r_alvo[i]  <= MIN_W;
            end
            r_hab <= '0;
        end else begin
            // NOTE: non-blocking, so a write on the boundary edge leaves this ramp using the old target.
            if (w_fim) begin
                r_atual <= w_atual_prox;
            end
            if (w_escrita_valida) begin
                r_alvo[canal] <= w_alvo_novo;
                r_hab[canal]  <= habilita;
            end
        end
    end

    // Registered pulse outputs and end-of-period strobe, both one cycle behind the counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_controle    <= '0;
            r_fim_periodo <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CANAIS; i++) begin
                r_controle[i] <= r_hab[i] && ({1'b0, r_contador} < r_atual[i]);
            end
            r_fim_periodo <= w_fim;
        end
    end

    // A channel is moving while its current width has not reached the target.
    always_comb begin
        for (int i = 0; i < NUM_CANAIS; i++) begin
            w_movimento[i] = (r_atual[i] != r_alvo[i]);
        end
    end

    assign controle       = r_controle;
    assign em_movimento   = w_movimento;
    assign db_controle    = w_canal_valido ? r_controle[canal] : 1'b0;
    assign db_fim_periodo = r_fim_periodo;

endmodule

// File: tb/tb_controle_servo_multicanal.sv
// Bench for controle_servo_multicanal: directed write table, boundary and reset
// sequences, then random traffic checked against a period-level reference model.
module tb_controle_servo_multicanal;

    localparam int P    = 100;
    localparam int LMIN = 10;
    localparam int INC  = 1;
    localparam int PB   = 4;
    localparam int PS   = 5;
    localparam int NC   = 2;

    logic          clock    = 1'b0;
    logic          reset    = 1'b1;
    logic          escreve  = 1'b0;
    logic [0:0]    canal    = '0;
    logic [PB-1:0] posicao  = '0;
    logic          habilita = 1'b0;
    logic [NC-1:0] controle;
    logic [NC-1:0] em_movimento;
    logic          db_controle;
    logic          db_fim_periodo;

    // Three-channel instance: its 2-bit canal can address a non-existent channel.
    logic          escreve3 = 1'b0;
    logic [1:0]    canal3   = '0;
    logic [2:0]    controle3;
    logic [2:0]    em_movimento3;
    logic          db_controle3;
    logic          db_fim3;

    controle_servo_multicanal #(
        .NUM_CANAIS(NC), .POS_BITS(PB), .PERIODO(P),
        .LARGURA_MIN(LMIN), .INCREMENTO(INC), .PASSO(PS)
    ) dut (
        .clock(clock), .reset(reset), .escreve(escreve), .canal(canal),
        .posicao(posicao), .habilita(habilita), .controle(controle),
        .em_movimento(em_movimento), .db_controle(db_controle),
        .db_fim_periodo(db_fim_periodo)
    );

    controle_servo_multicanal #(
        .NUM_CANAIS(3), .POS_BITS(PB), .PERIODO(P),
        .LARGURA_MIN(LMIN), .INCREMENTO(INC), .PASSO(PS)
    ) dut3 (
        .clock(clock), .reset(reset), .escreve(escreve3), .canal(canal3),
        .posicao(posicao), .habilita(habilita), .controle(controle3),
        .em_movimento(em_movimento3), .db_controle(db_controle3),
        .db_fim_periodo(db_fim3)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inputs as seen by the DUT at the last rising edge.
    logic          cap_rst = 1'b1;
    logic          cap_esc = 1'b0;
    logic [0:0]    cap_canal;
    logic [PB-1:0] cap_pos;
    logic          cap_hab;

    initial forever begin
        @(posedge clock);
        cap_rst   = reset;
        cap_esc   = escreve;
        cap_canal = canal;
        cap_pos   = posicao;
        cap_hab   = habilita;
    end

    // Reference model: phase within the period plus each channel's widths and enable.
    int       ph = 0;
    int       m_atual [NC];
    int       m_alvo  [NC];
    bit       m_hab   [NC];
    int       exp_cnt [NC];
    int       meas_cnt[NC];
    int       last_w  [NC];
    logic [1:0] last_mov;
    int       bad_fim = 0;
    int       bad_dbc = 0;
    int       period_cnt = 0;

    function automatic int ramp(input int atual, input int alvo);
        if (PS == 0)          return alvo;
        if (atual + PS < alvo) return atual + PS;
        if (atual - PS > alvo) return atual - PS;
        return alvo;
    endfunction

    // Each falling-edge sample shows the outputs computed at counter value ph.
    initial forever begin
        @(negedge clock);
        if (cap_rst) begin
            check("reset_outputs", {26'd0, controle, em_movimento, db_controle, db_fim_periodo}, 32'd0);
            ph = 0;
            bad_fim = 0;
            bad_dbc = 0;
            for (int i = 0; i < NC; i++) begin
                m_atual[i]  = LMIN;
                m_alvo[i]   = LMIN;
                m_hab[i]    = 1'b0;
                exp_cnt[i]  = 0;
                meas_cnt[i] = 0;
            end
        end else begin
            for (int i = 0; i < NC; i++) begin
                exp_cnt[i]  += (m_hab[i] && ph < m_atual[i]) ? 1 : 0;
                meas_cnt[i] += controle[i] ? 1 : 0;
            end
            if (db_controle !== (m_hab[canal] && ph < m_atual[canal])) bad_dbc++;
            if (db_fim_periodo !== (ph == P - 1)) bad_fim++;
            if (ph == 50) last_mov = em_movimento;
            if (ph == P - 1) begin
                for (int i = 0; i < NC; i++) begin
                    check($sformatf("pulse_width_ch%0d", i), meas_cnt[i], exp_cnt[i]);
                    last_w[i] = meas_cnt[i];
                    m_atual[i] = ramp(m_atual[i], m_alvo[i]);
                end
                check("fim_align", bad_fim, 0);
                check("db_controle", bad_dbc, 0);
            end
            if (cap_esc) begin
                m_alvo[cap_canal] = LMIN + int'(cap_pos) * INC;
                m_hab[cap_canal]  = cap_hab;
            end
            if (ph == P - 1) begin
                check("em_movimento", em_movimento,
                      {30'd0, m_atual[1] != m_alvo[1], m_atual[0] != m_alvo[0]});
                bad_fim = 0;
                bad_dbc = 0;
                for (int i = 0; i < NC; i++) begin
                    exp_cnt[i]  = 0;
                    meas_cnt[i] = 0;
                end
                period_cnt++;
            end
            ph = (ph + 1) % P;
        end
    end

    // Return at negedge+1 once the next sample will show counter value k.
    task automatic wait_ph(input int k);
        int t = 0;
        while (ph != k && t < 2 * P + 2) begin
            @(negedge clock); #1;
            t++;
        end
        check("wait_ph_timeout", ph, k);
    endtask

    task automatic wait_period_end();
        int start = period_cnt;
        int t = 0;
        while (period_cnt == start && t < 2 * P + 2) begin
            @(negedge clock); #1;
            t++;
        end
        check("period_timeout", period_cnt - start, 1);
    endtask

    // One-cycle write, captured on the edge that produces sample at_ph.
    task automatic do_write(input logic [0:0] c, input logic [PB-1:0] pos, input logic hab, input int at_ph);
        wait_ph(at_ph);
        escreve  = 1'b1;
        canal    = c;
        posicao  = pos;
        habilita = hab;
        @(negedge clock); #1;
        escreve = 1'b0;
    endtask

    // Write, then the widths and moving flags of the four following periods.
    typedef struct {
        logic [0:0]      canal;
        logic [PB-1:0]   pos;
        logic            hab;
        logic [3:0][7:0] w0;
        logic [3:0][7:0] w1;
        logic [3:0][1:0] mov;
    } vec_t;

    vec_t tab[5];

    initial begin
        int bad;

        // Element [0] is the first period after the write.
        tab[0] = '{canal: 1'b0, pos: 4'd15, hab: 1'b1,
                   w0: {8'd25, 8'd25, 8'd20, 8'd15}, w1: {8'd0, 8'd0, 8'd0, 8'd0},
                   mov: {2'b00, 2'b00, 2'b01, 2'b01}};
        tab[1] = '{canal: 1'b1, pos: 4'd8, hab: 1'b1,
                   w0: {8'd25, 8'd25, 8'd25, 8'd25}, w1: {8'd18, 8'd18, 8'd18, 8'd15},
                   mov: {2'b00, 2'b00, 2'b00, 2'b10}};
        tab[2] = '{canal: 1'b0, pos: 4'd0, hab: 1'b1,
                   w0: {8'd10, 8'd10, 8'd15, 8'd20}, w1: {8'd18, 8'd18, 8'd18, 8'd18},
                   mov: {2'b00, 2'b00, 2'b01, 2'b01}};
        tab[3] = '{canal: 1'b0, pos: 4'd15, hab: 1'b0,
                   w0: {8'd0, 8'd0, 8'd0, 8'd0}, w1: {8'd18, 8'd18, 8'd18, 8'd18},
                   mov: {2'b00, 2'b00, 2'b01, 2'b01}};
        tab[4] = '{canal: 1'b0, pos: 4'd15, hab: 1'b1,
                   w0: {8'd25, 8'd25, 8'd25, 8'd25}, w1: {8'd18, 8'd18, 8'd18, 8'd18},
                   mov: {2'b00, 2'b00, 2'b00, 2'b00}};

        // Reset held for three cycles.
        repeat (3) @(negedge clock);
        #1;
        reset = 1'b0;

        // Out-of-range channel on the three-channel instance changes nothing.
        wait_ph(10);
        escreve3 = 1'b1;
        canal3   = 2'd3;
        posicao  = 4'd15;
        habilita = 1'b1;
        @(negedge clock); #1;
        escreve3 = 1'b0;
        bad = 0;
        for (int n = 0; n < P; n++) begin
            @(negedge clock);
            if (controle3 !== 3'b000 || em_movimento3 !== 3'b000 || db_controle3 !== 1'b0) bad++;
            #1;
        end
        check("oob_write_ignored", bad, 0);
        canal3   = 2'd2;
        escreve3 = 1'b1;
        @(negedge clock);
        check("dut3_ch2_write", {29'd0, em_movimento3}, 32'd4);
        #1;
        escreve3 = 1'b0;

        // No pulses before any enabling write.
        wait_period_end();
        wait_period_end();
        check("idle_w0", last_w[0], 0);
        check("idle_w1", last_w[1], 0);

        // Write table.
        for (int v = 0; v < 5; v++) begin
            do_write(tab[v].canal, tab[v].pos, tab[v].hab, 50);
            wait_period_end();
            for (int k = 0; k < 4; k++) begin
                wait_period_end();
                check($sformatf("tab%0d_p%0d_w0", v, k), last_w[0], {24'd0, tab[v].w0[k]});
                check($sformatf("tab%0d_p%0d_w1", v, k), last_w[1], {24'd0, tab[v].w1[k]});
                check($sformatf("tab%0d_p%0d_mov", v, k), {30'd0, last_mov}, {30'd0, tab[v].mov[k]});
            end
        end

        // Write on the boundary edge: ramp uses the old target (18), new one afterwards.
        do_write(1'b1, 4'd0, 1'b1, P - 1);
        wait_period_end();
        check("bnd_w1_p0", last_w[1], 18);
        wait_period_end();
        check("bnd_w1_p1", last_w[1], 13);
        wait_period_end();
        check("bnd_w1_p2", last_w[1], 10);

        // Reset sampled while contador=7 and channel 0 is mid-pulse.
        wait_ph(7);
        reset = 1'b1;
        @(negedge clock);
        check("midpulse_reset_ctrl", {30'd0, controle}, 32'd0);
        #1;
        @(negedge clock); #1;
        reset = 1'b0;
        wait_period_end();
        check("post_reset_w0", last_w[0], 0);
        do_write(1'b0, 4'd15, 1'b1, 50);
        wait_period_end();
        wait_period_end();
        check("post_reset_ramp_w0", last_w[0], 15);

        // Random traffic with one reset burst; the monitor's model does the checking.
        for (int n = 0; n < 4000; n++) begin
            escreve  = ($urandom_range(0, 15) == 0);
            canal    = 1'($urandom);
            posicao  = 4'($urandom);
            habilita = ($urandom_range(0, 3) != 0);
            reset    = (n >= 2000 && n < 2003);
            @(negedge clock); #1;
        end
        escreve = 1'b0;
        reset   = 1'b0;
        wait_period_end();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
